keypad_scan: RTL and testbench

//  4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 7-seg display driver.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_if.sv | 26 ++
 rtl/keypad_tick_div.sv | 28 ++
 rtl/keypad_scan.sv | 180 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared encodings and helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   typedef enum logic [1:0] {
      StScan     = SCAN,
      StDebounce = DEBOUNCE,
      StPressed  = PRESSED,
      StRelease  = RELEASE
   } state_e;

   localparam logic [3:0] COLS_IDLE = 4'hF;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Index of the lowest zero bit; an all-ones input maps to 3.
   function automatic logic [1:0] lowest_zero(input logic [3:0] v);
      if (!v[0]) begin
         return 2'd0;
      end else if (!v[1]) begin
         return 2'd1;
      end else if (!v[2]) begin
         return 2'd2;
      end else begin
         return 2'd3;
      end
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle; master is the scanner, slave the board/consumer side.
interface keypad_scan_if;

   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  col_n,
      output row_n,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output col_n,
      input  row_n,
      input  key_code,
      input  key_valid,
      input  key_held
   );

endinterface

// File: rtl/keypad_tick_div.sv
// Free-running 1..SCAN_DIV counter; tick is high for the one cycle the count equals SCAN_DIV.
module keypad_tick_div #(
   parameter int unsigned SCAN_DIV = 20000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int unsigned CW = $clog2(SCAN_DIV + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(SCAN_DIV));

   always_comb begin
      cnt_d = tick_o ? CW'(1) : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CW'(1);
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with tick-based debounce of press and release.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 20000,
   parameter int unsigned DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 10
`endif
) (
   input logic           clk,
   input logic           rst_n,
   keypad_scan_if.master bus
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);

   logic          tick;
   logic [3:0]    col_meta_q, cs_q;
   state_e        state_q, state_d;
   logic [3:0]    row_q, row_d;
   logic [3:0]    pat_q, pat_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          held_q, held_d;
   logic          accept;
   logic [DW-1:0] deb_inc;
   logic [3:0]    row_rot;

   assign deb_inc = deb_q + DW'(1);
   assign row_rot = {row_q[2:0], row_q[3]};

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW     = $clog2(RepMax + 1);

   logic [RW-1:0] rep_q, rep_d, rep_inc, rep_target;
   logic          rep_armed_q, rep_armed_d;

   assign rep_inc    = rep_q + RW'(1);
   // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE.
   assign rep_target = rep_armed_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
`endif

   keypad_tick_div #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      pat_d   = pat_q;
      deb_d   = deb_q;
      code_d  = code_q;
      valid_d = 1'b0;
      held_d  = held_q;
      accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = rep_q;
      rep_armed_d = rep_armed_q;
`endif
      if (tick) begin
         unique case (state_q)
            StScan: begin
               if (cs_q == COLS_IDLE) begin
                  row_d = row_rot;
               end else begin
                  pat_d = cs_q;
                  deb_d = DW'(1);
                  if (DEBOUNCE_CNT == 1) begin
                     accept = 1'b1;
                  end else begin
                     state_d = StDebounce;
                  end
               end
            end
            StDebounce: begin
               if (cs_q == pat_q) begin
                  deb_d = deb_inc;
                  if (deb_inc == DW'(DEBOUNCE_CNT)) begin
                     accept = 1'b1;
                  end
               end else begin
                  state_d = StScan;
                  row_d   = row_rot;
               end
            end
            StPressed: begin
               if (cs_q == COLS_IDLE) begin
                  deb_d = DW'(1);
                  if (DEBOUNCE_CNT == 1) begin
                     held_d  = 1'b0;
                     state_d = StScan;
                  end else begin
                     state_d = StRelease;
                  end
               end
`ifdef KEYPAD_REPEAT_EN
               else if (rep_inc == rep_target) begin
                  valid_d     = 1'b1;
                  rep_d       = '0;
                  rep_armed_d = 1'b1;
               end else begin
                  rep_d = rep_inc;
               end
`endif
            end
            StRelease: begin
               if (cs_q == COLS_IDLE) begin
                  deb_d = deb_inc;
                  if (deb_inc == DW'(DEBOUNCE_CNT)) begin
                     held_d  = 1'b0;
                     state_d = StScan;
                  end
               end else begin
                  state_d = StPressed;
               end
            end
            default: state_d = StScan;
         endcase
      end
      // On accept cs_q equals the latched pattern, so either can give the column.
      if (accept) begin
         code_d  = {lowest_zero(row_q), lowest_zero(cs_q)};
         valid_d = 1'b1;
         held_d  = 1'b1;
         state_d = StPressed;
`ifdef KEYPAD_REPEAT_EN
         rep_d       = '0;
         rep_armed_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= COLS_IDLE;
         cs_q       <= COLS_IDLE;
         state_q    <= StScan;
         row_q      <= ROW_RESET;
         pat_q      <= COLS_IDLE;
         deb_q      <= '0;
         code_q     <= 4'h0;
         valid_q    <= 1'b0;
         held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= '0;
         rep_armed_q <= 1'b0;
`endif
      end else begin
         col_meta_q <= bus.col_n;
         cs_q       <= col_meta_q;
         state_q    <= state_d;
         row_q      <= row_d;
         pat_q      <= pat_d;
         deb_q      <= deb_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= rep_d;
         rep_armed_q <= rep_armed_d;
`endif
      end
   end

   assign bus.row_n     = row_q;
   assign bus.key_code  = code_q;
   assign bus.key_valid = valid_q;
   assign bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical 4x4 key matrix drives col_n from row_n; expectations
// come from tick arithmetic (ticks on every SD-th edge after reset) and key geometry.
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DC = 3;
`ifdef KEYPAD_REPEAT_EN
   localparam int RD = 5;
   localparam int RR = 2;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   keypad_scan_if bus ();

   keypad_scan #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DC)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // keys[r][c] = 1 means the switch at row r, column c is closed.
   logic [3:0] keys [4];
   logic [3:0] col_mdl;
   always_comb begin
      col_mdl = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!bus.row_n[r]) col_mdl = col_mdl & ~keys[r];
      end
   end
   assign bus.col_n = col_mdl;

   int checks = 0;
   int errors = 0;
   int edge_n;
   int pulse_cnt = 0;
   int last_pulse_edge = -1;
   logic prev_valid = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   always @(negedge clk) begin
      if (bus.key_valid === 1'b1) begin
         pulse_cnt++;
         last_pulse_edge = edge_n;
         checks++;
         assert (prev_valid === 1'b0) else begin
            errors++;
            $error("FAIL valid_single_cycle observed=%b expected=0", prev_valid);
         end
      end
      prev_valid = bus.key_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] row_of(input int i);
      logic [3:0] v;
      v = 4'b0001 << i;
      return ~v;
   endfunction

   function automatic int reps(input int h);
`ifdef KEYPAD_REPEAT_EN
      return (h >= RD) ? (h - RD) / RR + 1 : 0;
`else
      return (h < 0) ? 1 : 0;
`endif
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 1000 && edge_n < target; i++) step();
   endtask

   task automatic wait_row_tick(input logic [3:0] target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         step();
         if (bus.row_n === target && edge_n % SD == 0) ok = 1'b1;
      end
   endtask

   task automatic wait_pulse(input int p0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         step();
         if (pulse_cnt != p0) ok = 1'b1;
      end
   endtask

   task automatic wait_held_low(output bit ok, output int at);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < 200 && !ok; i++) begin
         step();
         if (bus.key_held === 1'b0) begin
            ok = 1'b1;
            at = edge_n;
         end
      end
   endtask

   initial begin
      bit ok;
      int e, f, p0, at, r, c, h;
      logic [3:0] pat;

      for (int i = 0; i < 4; i++) keys[i] = 4'h0;
      #2 rst_n = 1'b0;
      repeat (3) step();
      chk("rst_row_n", bus.row_n, 4'b1110);
      chk("rst_key_code", bus.key_code, 4'h0);
      chk("rst_key_valid", bus.key_valid, 1'b0);
      chk("rst_key_held", bus.key_held, 1'b0);
      rst_n = 1'b1;

      // Idle scan: one row step per SD clocks.
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_row_n", bus.row_n, row_of((edge_n / SD) % 4));
      end
      chk("idle_pulses", pulse_cnt, 0);

      // Clean press of row 2 / col 1, then release with a one-tick glitch.
      wait_row_tick(4'b1011, ok);
      chk("press_row_wait", ok, 1'b1);
      keys[2] = 4'b0010;
      e = edge_n;
      p0 = pulse_cnt;
      wait_pulse(p0, ok);
      chk("press_pulse_seen", ok, 1'b1);
      chk("press_latency", last_pulse_edge, e + SD * DC);
      chk("press_code", bus.key_code, 4'h9);
      chk("press_held", bus.key_held, 1'b1);
      chk("press_row_frozen", bus.row_n, 4'b1011);
      repeat (2 * SD) step();
      chk("press_single", pulse_cnt, p0 + 1);
      f = edge_n;
      keys[2] = 4'b0000;
      run_to(f + SD);
      keys[2] = 4'b0010;
      run_to(f + 2 * SD);
      keys[2] = 4'b0000;
      chk("glitch_held", bus.key_held, 1'b1);
      run_to(f + 5 * SD - 1);
      chk("release_held_before", bus.key_held, 1'b1);
      run_to(f + 5 * SD);
      chk("release_held_after", bus.key_held, 1'b0);
      chk("release_no_pulse", pulse_cnt, p0 + 1);
      chk("release_code_kept", bus.key_code, 4'h9);
      run_to(f + 6 * SD - 1);
      chk("release_row_stays", bus.row_n, 4'b1011);
      run_to(f + 6 * SD);
      chk("release_row_rotates", bus.row_n, 4'b0111);

      // Bounce: toggle every 3 clocks for 40 clocks, then hold.
      p0 = pulse_cnt;
      for (int i = 0; i < 40; i++) begin
         keys[2] = ((i / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
         step();
      end
      chk("bounce_quiet", pulse_cnt, p0);
      keys[2] = 4'b0010;
      wait_pulse(p0, ok);
      chk("bounce_pulse_seen", ok, 1'b1);
      chk("bounce_code", bus.key_code, 4'h9);
      repeat (3 * SD) step();
      chk("bounce_single", pulse_cnt, p0 + 1);
      keys[2] = 4'b0000;
      wait_held_low(ok, at);
      chk("bounce_release", ok, 1'b1);

      // Two keys on row 0 resolve to the lower column.
      wait_row_tick(4'b1110, ok);
      chk("multi_row_wait", ok, 1'b1);
      keys[0] = 4'b1010;
      e = edge_n;
      p0 = pulse_cnt;
      wait_pulse(p0, ok);
      chk("multi_pulse_seen", ok, 1'b1);
      chk("multi_latency", last_pulse_edge, e + SD * DC);
      chk("multi_code", bus.key_code, 4'h1);
      keys[0] = 4'b0000;
      wait_held_low(ok, at);
      chk("multi_release", ok, 1'b1);

      // Reset while debouncing.
      wait_row_tick(4'b1110, ok);
      chk("rstmid_row_wait", ok, 1'b1);
      keys[0] = 4'b0010;
      e = edge_n;
      p0 = pulse_cnt;
      run_to(e + SD + 2);
      rst_n = 1'b0;
      #1;
      chk("rstmid_row_n", bus.row_n, 4'b1110);
      chk("rstmid_key_code", bus.key_code, 4'h0);
      chk("rstmid_key_valid", bus.key_valid, 1'b0);
      chk("rstmid_key_held", bus.key_held, 1'b0);
      keys[0] = 4'b0000;
      step();
      rst_n = 1'b1;
      repeat (6 * SD) step();
      chk("rstmid_no_pulse", pulse_cnt, p0);

      // Randomized presses with random hold lengths.
      for (int it = 0; it < 8; it++) begin
         r = int'($urandom_range(3, 0));
         c = int'($urandom_range(3, 0));
         h = int'($urandom_range(12, 1));
         pat = 4'b0001 << c;
         if ($urandom_range(1, 0) == 1 && c < 3) pat = pat | (4'b0001 << $urandom_range(3, c + 1));
         wait_row_tick(row_of(r), ok);
         chk("rand_row_wait", ok, 1'b1);
         keys[r] = pat;
         e = edge_n;
         p0 = pulse_cnt;
         wait_pulse(p0, ok);
         chk("rand_pulse_seen", ok, 1'b1);
         chk("rand_latency", last_pulse_edge, e + SD * DC);
         chk("rand_code", bus.key_code, {28'h0, 2'(r), 2'(c)});
         chk("rand_held", bus.key_held, 1'b1);
         run_to(e + SD * DC + SD * h);
         keys[r] = 4'b0000;
         f = edge_n;
         wait_held_low(ok, at);
         chk("rand_release_seen", ok, 1'b1);
         chk("rand_release_latency", at, f + SD * DC);
         chk("rand_pulse_count", pulse_cnt, p0 + 1 + reps(h));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
